fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the control unit and register-file decode. It owns the program counter and issues one-byte read requests to instruction memory. Returned bytes are buffered in a small FIFO and presented as split {opcode, immediate} fields with a valid/ready handshake. Branches reach it through a redirect port, which flushes buffered and in-flight instructions and restarts fetch at the target address.

---
 rtl/fetch_unit.sv | 151 +++++++++++++++
 tb/tb_fetch_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Owns the program counter and issues one-byte reads to instruction memory.
// Returned bytes go into a small queue and are presented as {opcode, immediate}
// together with their fetch address, under a valid/ready handshake. A redirect
// flushes queued and in-flight instructions and restarts fetch at the target.
// Optional feature: define FETCH_HALT_EN to make byte 0xFF stop fetch until the
// next redirect or reset.
module fetch_unit #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [7:0]               mem_rdata,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [2:0]               opcode,
  output logic [4:0]               immediate,
  output logic [ADDR_W-1:0]        instr_pc,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_addr,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     halted
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 8 + ADDR_W;

  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic               inflight_q, inflight_d;
  logic [ADDR_W-1:0]  inflight_addr_q, inflight_addr_d;
  logic               discard_q, discard_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ENTRY_W-1:0] q_mem_q [DEPTH];

  logic               push;
  logic               pop;
  logic               halt_block;
  logic               has_room;
  logic [CNT_W-1:0]   occupancy;
  logic [ENTRY_W-1:0] head;

`ifdef FETCH_HALT_EN
  logic halted_q, halted_d;
  logic halt_now;
`endif

  // Issue / push / pop decisions for this cycle; redirect overrides all of them.
  always_comb begin
    push      = rst_n && !redirect && inflight_q && !discard_q;
    pop       = rst_n && !redirect && instr_valid && instr_ready;
    // Room check counts the outstanding request but deliberately ignores a same-cycle pop.
    occupancy = count_q + {{(CNT_W-1){1'b0}}, inflight_q};
    has_room  = (occupancy < CNT_W'(DEPTH));
`ifdef FETCH_HALT_EN
    // A halt byte arriving this cycle already blocks the next request.
    halt_now   = push && (mem_rdata == 8'hFF);
    halt_block = halted_q || halt_now;
`else
    halt_block = 1'b0;
`endif
    mem_req  = rst_n && !redirect && !halt_block && has_room;
    mem_addr = fetch_pc_q;
  end

  // Next-state for PC, in-flight tracking, pointers and occupancy.
  always_comb begin
    fetch_pc_d      = fetch_pc_q;
    inflight_d      = mem_req;
    inflight_addr_d = fetch_pc_q;
    discard_d       = 1'b0;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    count_d         = count_q;
`ifdef FETCH_HALT_EN
    halted_d        = halted_q || halt_now;
`endif
    if (redirect) begin
      fetch_pc_d = redirect_addr;
      discard_d  = inflight_q || (!halt_block && has_room);
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
`ifdef FETCH_HALT_EN
      halted_d   = 1'b0;
`endif
    end else begin
      if (mem_req) fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      if (push)    wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      discard_q       <= 1'b0;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
`ifdef FETCH_HALT_EN
      halted_q        <= 1'b0;
`endif
    end else begin
      fetch_pc_q      <= fetch_pc_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
      discard_q       <= discard_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
`ifdef FETCH_HALT_EN
      halted_q        <= halted_d;
`endif
    end
  end

  // Queue storage: data only, no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) q_mem_q[wr_ptr_q] <= {mem_rdata, inflight_addr_q};
  end

  // Head fields decoded straight from the entry at the read pointer.
  always_comb begin
    head        = q_mem_q[rd_ptr_q];
    instr_valid = (count_q != '0);
    opcode      = head[ENTRY_W-1 -: 3];
    immediate   = head[ADDR_W+4 : ADDR_W];
    instr_pc    = head[ADDR_W-1:0];
    q_count     = count_q;
`ifdef FETCH_HALT_EN
    halted      = halted_q;
`else
    halted      = 1'b0;
`endif
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit (DEPTH=4, ADDR_W=8).
// Memory model returns mem[addr] one cycle after each request.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata = 8'h00;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] opcode;
  logic [4:0] immediate;
  logic [7:0] instr_pc;
  logic       redirect;
  logic [7:0] redirect_addr;
  logic [2:0] q_count;
  logic       halted;

  logic [7:0] mem [256];
  int total = 0;
  int bad   = 0;

  fetch_unit #(.DEPTH(4), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .immediate(immediate), .instr_pc(instr_pc),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .q_count(q_count), .halted(halted)
  );

  always #5 clk = ~clk;

  // Instruction memory: one-cycle read latency.
  always @(posedge clk) begin
    if (mem_req) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven from here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect = 1'b0;
    cyc();
    cyc();
  endtask

  function automatic logic [7:0] exp_byte(input logic [7:0] pc);
    return pc ^ 8'hA5;
  endfunction

  task automatic check_head(input string tag, input logic [7:0] pc, input logic [7:0] b);
    check({tag, "_vld"}, instr_valid, 1);
    check({tag, "_pc"},  instr_pc, pc);
    check({tag, "_op"},  opcode, b[7:5]);
    check({tag, "_imm"}, immediate, b[4:0]);
  endtask

  initial begin
    int nreq;
    logic [7:0] pcs [4];
    rst_n = 1'b0; instr_ready = 1'b1; redirect = 1'b0; redirect_addr = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;

    // Reset state
    do_reset();
    #2;
    check("rst_req", mem_req, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_vld", instr_valid, 0);
    check("rst_cnt", q_count, 0);
    check("rst_halt", halted, 0);

    // Sequential fetch
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #2;
      check("seq_req", mem_req, 1);
      check("seq_addr", mem_addr, k);
      if (k < 2) check("seq_vld0", instr_valid, 0);
      else check_head("seq", 8'(k - 2), exp_byte(8'(k - 2)));
      cyc();
    end

    // Backpressure: queue fills with exactly DEPTH entries
    instr_ready = 1'b0;
    do_reset();
    rst_n = 1'b1;
    nreq = 0;
    for (int k = 0; k < 8; k++) begin
      #2;
      if (mem_req) begin
        check("bp_addr", mem_addr, nreq);
        nreq++;
      end
      cyc();
    end
    #2;
    check("bp_nreq", nreq, 4);
    check("bp_cnt", q_count, 4);
    check("bp_req", mem_req, 0);
    check_head("bp_head", 8'h00, exp_byte(8'h00));
    cyc();
    instr_ready = 1'b1;
    #2;
    check_head("bp_d0", 8'h00, exp_byte(8'h00));
    check("bp_d0_req", mem_req, 0);
    cyc(); #2;
    check_head("bp_d1", 8'h01, exp_byte(8'h01));
    check("bp_d1_req", mem_req, 1);
    check("bp_d1_addr", mem_addr, 4);
    cyc(); #2;
    check_head("bp_d2", 8'h02, exp_byte(8'h02));
    check("bp_d2_addr", mem_addr, 5);
    cyc(); #2;
    check_head("bp_d3", 8'h03, exp_byte(8'h03));
    cyc(); #2;
    check_head("bp_d4", 8'h04, exp_byte(8'h04));

    // Redirect while the request for 0x05 is in flight
    cyc();
    do_reset();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) begin #2; check("rd_pre_addr", mem_addr, 5); end
      cyc();
    end
    redirect = 1'b1; redirect_addr = 8'h40;
    #2;
    check("rd_r_req", mem_req, 0);
    cyc();
    redirect = 1'b0;
    #2;
    check("rd_r1_cnt", q_count, 0);
    check("rd_r1_vld", instr_valid, 0);
    check("rd_r1_req", mem_req, 1);
    check("rd_r1_addr", mem_addr, 8'h40);
    cyc(); #2;
    check("rd_r2_vld", instr_valid, 0);
    check("rd_r2_addr", mem_addr, 8'h41);
    cyc(); #2;
    check_head("rd_r3", 8'h40, exp_byte(8'h40));
    cyc(); #2;
    check_head("rd_r4", 8'h41, exp_byte(8'h41));

    // Wrap-around of the program counter
    cyc();
    redirect = 1'b1; redirect_addr = 8'hFE;
    cyc();
    redirect = 1'b0;
    cyc();
    cyc();
    pcs[0] = 8'hFE; pcs[1] = 8'hFF; pcs[2] = 8'h00; pcs[3] = 8'h01;
    for (int k = 0; k < 4; k++) begin
      #2;
      check_head("wrap", pcs[k], exp_byte(pcs[k]));
      cyc();
    end

    // Halt byte at address 3
    mem[3] = 8'hFF;
    do_reset();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) cyc();
    #2;
`ifdef FETCH_HALT_EN
    check("halt_c4_req", mem_req, 0);
    check_head("halt_c4", 8'h02, exp_byte(8'h02));
    cyc(); #2;
    check("halt_c5_halted", halted, 1);
    check("halt_c5_req", mem_req, 0);
    check_head("halt_c5", 8'h03, 8'hFF);
    cyc(); #2;
    check("halt_c6_vld", instr_valid, 0);
    check("halt_c6_req", mem_req, 0);
    cyc();
    redirect = 1'b1; redirect_addr = 8'h10;
    cyc();
    redirect = 1'b0;
    #2;
    check("halt_rd_halted", halted, 0);
    check("halt_rd_req", mem_req, 1);
    check("halt_rd_addr", mem_addr, 8'h10);
    cyc(); cyc(); #2;
    check_head("halt_rd", 8'h10, exp_byte(8'h10));
`else
    check("nohalt_c4_req", mem_req, 1);
    check("nohalt_c4_addr", mem_addr, 4);
    cyc(); #2;
    check("nohalt_c5_halted", halted, 0);
    check_head("nohalt_c5", 8'h03, 8'hFF);
    cyc(); #2;
    check_head("nohalt_c6", 8'h04, exp_byte(8'h04));
    check("nohalt_c6_halted", halted, 0);
`endif
    mem[3] = exp_byte(8'h03);

    // Reset mid-operation with three queued entries and one in flight
    cyc();
    instr_ready = 1'b0;
    do_reset();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) cyc();
    rst_n = 1'b0;
    #2;
    check("mr_pre_cnt", q_count, 3);
    check("mr_pre_req", mem_req, 0);
    cyc();
    rst_n = 1'b1;
    #2;
    check("mr_cnt", q_count, 0);
    check("mr_vld", instr_valid, 0);
    check("mr_req", mem_req, 1);
    check("mr_addr", mem_addr, 0);
    cyc(); #2;
    check("mr_drop_cnt", q_count, 0);
    check("mr_addr1", mem_addr, 1);
    cyc(); #2;
    check("mr_cnt1", q_count, 1);
    check_head("mr_head", 8'h00, exp_byte(8'h00));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
